// File: rtl/acl_sample_sequencer.sv
// Purpose : periodic X/Y/Z accelerometer reader; turns each byte into sign + 4-bit magnitude.
// Latency : tick in T -> first spi_req in T+1; last ack in k -> acl_data/acl_valid in k+1.
// Backpres: a request waits on spi_ack up to ACK_TIMEOUT cycles; ticks while busy are dropped.
//
// Ports:
//   CLK100MHZ   in   system clock, rising edge
//   CPU_RESETN  in   asynchronous active-low reset
//   enable      in   1 = periodic sampling runs, 0 = period counter held at 0
//   err_clr     in   one-cycle pulse, clears timeout_err and overrun
//   spi_req     out  read request, held until spi_ack
//   spi_addr    out  register address (0x08/0x09/0x0A), stable while spi_req = 1
//   spi_ack     in   one-cycle completion pulse
//   spi_rdata   in   read byte, valid with spi_ack
//   acl_data    out  {x_sign, x_mag, y_sign, y_mag, z_sign, z_mag}
//   acl_valid   out  one-cycle pulse when acl_data updates
//   busy        out  frame in progress
//   timeout_err out  sticky, ack did not arrive in time
//   overrun     out  sticky, tick arrived while busy
module acl_sample_sequencer #(
   parameter int unsigned SAMPLE_PERIOD = 10_000_000,
   parameter int unsigned ACK_TIMEOUT   = 1024,
   parameter int unsigned MAG_SHIFT     = 3
) (
   input  logic        CLK100MHZ,
   input  logic        CPU_RESETN,
   input  logic        enable,
   input  logic        err_clr,
   output logic        spi_req,
   output logic [7:0]  spi_addr,
   input  logic        spi_ack,
   input  logic [7:0]  spi_rdata,
   output logic [14:0] acl_data,
   output logic        acl_valid,
   output logic        busy,
   output logic        timeout_err,
   output logic        overrun
);

   localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   // S_GAP is the one idle cycle between axes: the SPI master must see
   // spi_req low for a cycle after each ack before the next request.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_WAIT    = 3'd2,
      S_GAP     = 3'd3,
      S_PUBLISH = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [PW-1:0]   r_period_cnt;
   logic [TW-1:0]   r_to_cnt;
   logic [1:0]      r_axis;
   logic [9:0]      r_shadow;
   logic [14:0]     r_acl_data;
   logic            r_timeout_err;
   logic            r_overrun;

   logic            w_tick;
   logic            w_busy;
   logic            w_to_expired;
   logic            w_wait_ack;
   logic            w_wait_to;
   logic [8:0]      w_abs;
   logic [8:0]      w_shr;
   logic [4:0]      w_field;

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   // enable gates the tick so a count left at SAMPLE_PERIOD-1 in the
   // cycle enable falls cannot start a frame.
   assign w_tick       = enable && (r_period_cnt == PW'(SAMPLE_PERIOD - 1));
   assign w_busy       = (r_state != S_IDLE);
   // r_to_cnt counts cycles spi_req has already been high, so expiry at
   // ACK_TIMEOUT-1 keeps spi_req high for exactly ACK_TIMEOUT cycles.
   assign w_to_expired = (r_to_cnt == TW'(ACK_TIMEOUT - 1));
   assign w_wait_ack   = (r_state == S_WAIT) && spi_ack;
   assign w_wait_to    = (r_state == S_WAIT) && !spi_ack && w_to_expired;

   // Sign + saturated magnitude. Negation is done in 9 bits so 0x80
   // becomes 128 instead of wrapping back to 0x80 as a negative value.
   always_comb begin
      w_abs   = spi_rdata[7] ? ({1'b0, ~spi_rdata} + 9'd1) : {1'b0, spi_rdata};
      w_shr   = w_abs >> MAG_SHIFT;
      w_field = {spi_rdata[7], (w_shr > 9'd15) ? 4'hF : w_shr[3:0]};
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_tick) begin
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // An ack in the expiry cycle still counts as a completed read.
            if (spi_ack) begin
               w_state_nxt = (r_axis == 2'd2) ? S_PUBLISH : S_GAP;
            end else if (w_to_expired) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_GAP: begin
            w_state_nxt = S_REQ;
         end
         S_PUBLISH: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs (decoded from state so reset drops spi_req at once)
   // ------------------------------------------------------------------
   always_comb begin
      spi_req     = (r_state == S_REQ) || (r_state == S_WAIT);
      spi_addr    = spi_req ? (8'h08 + {6'd0, r_axis}) : 8'h00;
      busy        = w_busy;
      acl_valid   = (r_state == S_PUBLISH);
      acl_data    = r_acl_data;
      timeout_err = r_timeout_err;
      overrun     = r_overrun;
   end

   // ------------------------------------------------------------------
   // Period counter
   // ------------------------------------------------------------------
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_period_cnt <= '0;
      end else if (!enable || w_tick) begin
         r_period_cnt <= '0;
      end else begin
         r_period_cnt <= r_period_cnt + PW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Axis index and ack timeout counter
   // ------------------------------------------------------------------
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_axis   <= 2'd0;
         r_to_cnt <= '0;
      end else begin
         if ((r_state == S_IDLE) && w_tick) begin
            r_axis <= 2'd0;
         end else if (w_wait_ack && (r_axis != 2'd2)) begin
            r_axis <= r_axis + 2'd1;
         end

         case (r_state)
            // The REQ cycle is the first cycle spi_req is high.
            S_REQ:   r_to_cnt <= TW'(1);
            S_WAIT:  r_to_cnt <= w_to_expired ? r_to_cnt : r_to_cnt + TW'(1);
            default: r_to_cnt <= '0;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Shadow and published sample word
   // ------------------------------------------------------------------
   // The Z field goes straight into acl_data together with the shadow, so
   // the new word is visible in the same cycle acl_valid pulses and a
   // partially read frame never reaches the output.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_shadow   <= '0;
         r_acl_data <= '0;
      end else begin
         if (w_wait_ack) begin
            case (r_axis)
               2'd0:    r_shadow[9:5] <= w_field;
               2'd1:    r_shadow[4:0] <= w_field;
               default: r_acl_data    <= {r_shadow, w_field};
            endcase
         end else if (w_wait_to) begin
            r_shadow <= '0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Sticky error flags; a set event beats err_clr in the same cycle
   // ------------------------------------------------------------------
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_timeout_err <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         if (w_wait_to) begin
            r_timeout_err <= 1'b1;
         end else if (err_clr) begin
            r_timeout_err <= 1'b0;
         end

         if (w_tick && w_busy) begin
            r_overrun <= 1'b1;
         end else if (err_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

endmodule
